smc_access_seq: RTL and testbench

Access sequencer for the static memory controller: accepts one memory request at a time from the bus-side interface and drives the external chip-select, output-enable and write-enable strobes. Setup, strobe, hold and read-turnaround phases have programmable lengths taken from the SMC timing configuration. It sits between the AHB slave front end and the memory pads, and completes each access with a single-cycle acknowledge and, for reads, captured read data.

---
 rtl/smc_access_seq.sv | 200 ++++++++++++++++++++
 tb/tb_smc_access_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_access_seq.sv
// rtl/smc_access_seq.sv - static memory access sequencer
// Runs one external access at a time through setup/strobe/hold/done/turnaround phases.
module smc_access_seq #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
) (
   input  logic              hclk,
   input  logic              n_sys_reset,
   input  logic              req,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        cfg_setup,
   input  logic [3:0]        cfg_strobe,
   input  logic [1:0]        cfg_hold,
   input  logic [1:0]        cfg_turn,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_cs_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              mem_drive,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE,
      ST_TURN
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        setup_q, setup_d;
   logic [3:0]        strobe_q, strobe_d;
   logic [1:0]        hold_q, hold_d;
   logic [1:0]        turn_q, turn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              cs_n_q, cs_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              drive_q, drive_d;
   logic              in_access;

   // Counter holds "cycles remaining minus one"; a zero strobe still gives one cycle.
   function automatic logic [3:0] strobe_load(input logic [3:0] s);
      return (s == 4'd0) ? 4'd0 : s - 4'd1;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      setup_d  = setup_q;
      strobe_d = strobe_q;
      hold_d   = hold_q;
      turn_d   = turn_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d     = req_we;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               setup_d  = cfg_setup;
               strobe_d = cfg_strobe;
               hold_d   = cfg_hold;
               turn_d   = cfg_turn;
               if (cfg_setup != 2'd0) begin
                  state_d = ST_SETUP;
                  cnt_d   = {2'b00, cfg_setup} - 4'd1;
               end else begin
                  state_d = ST_STROBE;
                  cnt_d   = strobe_load(cfg_strobe);
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_STROBE;
               cnt_d   = strobe_load(strobe_q);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               if (hold_q != 2'd0) begin
                  state_d = ST_HOLD;
                  cnt_d   = {2'b00, hold_q} - 4'd1;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (!we_q && (turn_q != 2'd0)) begin
               state_d = ST_TURN;
               cnt_d   = {2'b00, turn_q} - 4'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TURN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they line up with state cycles.
      in_access = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      ack_d     = (state_d == ST_DONE);
      busy_d    = (state_d != ST_IDLE);
      cs_n_d    = !in_access;
      oe_n_d    = !((state_d == ST_STROBE) && !we_d);
      we_n_d    = !((state_d == ST_STROBE) && we_d);
      drive_d   = in_access && we_d;
   end

   always_ff @(posedge hclk or negedge n_sys_reset) begin
      if (!n_sys_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         setup_q  <= 2'd0;
         strobe_q <= 4'd0;
         hold_q   <= 2'd0;
         turn_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         drive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         setup_q  <= setup_d;
         strobe_q <= strobe_d;
         hold_q   <= hold_d;
         turn_q   <= turn_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         cs_n_q   <= cs_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         drive_q  <= drive_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_cs_n  = cs_n_q;
   assign mem_oe_n  = oe_n_q;
   assign mem_we_n  = we_n_q;
   assign mem_drive = drive_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_smc_access_seq.sv
// tb/tb_smc_access_seq.sv - self-checking bench for smc_access_seq
// A cycle-window model predicts every output each cycle; directed tests add literal checks.
module tb_smc_access_seq;

   logic        hclk;
   logic        n_sys_reset;
   logic        req;
   logic        req_we;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  cfg_setup;
   logic [3:0]  cfg_strobe;
   logic [1:0]  cfg_hold;
   logic [1:0]  cfg_turn;
   logic        ack;
   logic [31:0] rdata;
   logic        busy;
   logic        mem_cs_n;
   logic        mem_oe_n;
   logic        mem_we_n;
   logic        mem_drive;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   smc_access_seq #(.ADDR_W(24), .DATA_W(32)) dut (
      .hclk(hclk), .n_sys_reset(n_sys_reset),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .cfg_setup(cfg_setup), .cfg_strobe(cfg_strobe), .cfg_hold(cfg_hold), .cfg_turn(cfg_turn),
      .ack(ack), .rdata(rdata), .busy(busy),
      .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_drive(mem_drive),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an access accepted at the end of cycle c0 occupies relative cycles
   // 1..S+P+H, acks at S+P+H+1, and is busy until S+P+H+1+T.
   int          cyc = 0;
   int          m_c0 = 0;
   int          m_s, m_p, m_h, m_t;
   logic        m_active = 1'b0;
   logic        m_we;
   logic [23:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;

   always @(posedge hclk or negedge n_sys_reset) begin
      int rel;
      if (!n_sys_reset) begin
         m_active = 1'b0;
         m_addr   = '0;
         m_wdata  = '0;
         m_rdata  = '0;
      end else begin
         rel = cyc - m_c0;
         if (m_active && !m_we && rel == m_s + m_p)
            m_rdata = mem_rdata;
         if ((!m_active || rel >= m_s + m_p + m_h + 2 + m_t) && req) begin
            m_active = 1'b1;
            m_c0     = cyc;
            m_we     = req_we;
            m_s      = int'(cfg_setup);
            m_p      = (cfg_strobe == 4'd0) ? 1 : int'(cfg_strobe);
            m_h      = int'(cfg_hold);
            m_t      = req_we ? 0 : int'(cfg_turn);
            m_addr   = req_addr;
            m_wdata  = req_wdata;
         end
      end
      if (hclk) cyc++;
   end

   always @(negedge hclk) begin
      int   rel;
      logic e_busy, e_ack, e_cs, e_str;
      rel    = cyc - m_c0;
      e_busy = 1'b0; e_ack = 1'b0; e_cs = 1'b0; e_str = 1'b0;
      if (n_sys_reset && m_active && rel >= 1 && rel <= m_s + m_p + m_h + 1 + m_t) begin
         e_busy = 1'b1;
         e_ack  = (rel == m_s + m_p + m_h + 1);
         e_cs   = (rel <= m_s + m_p + m_h);
         e_str  = (rel > m_s) && (rel <= m_s + m_p);
      end
      chk("busy", busy, e_busy);
      chk("ack", ack, e_ack);
      chk("mem_cs_n", mem_cs_n, !e_cs);
      chk("mem_oe_n", mem_oe_n, !(e_str && !m_we));
      chk("mem_we_n", mem_we_n, !(e_str && m_we));
      chk("mem_drive", mem_drive, e_cs && m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("rdata", rdata, m_rdata);
   end

   task automatic next_cycle();
      @(posedge hclk);
      #2;
   endtask

   task automatic observe(input int n, output int oe_lo, output int ack_hi, output int busy_hi);
      oe_lo = 0; ack_hi = 0; busy_hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge hclk);
         if (!mem_oe_n) oe_lo++;
         if (ack) ack_hi++;
         if (busy) busy_hi++;
         @(posedge hclk);
         #2;
      end
   endtask

   logic [9:1]  cs_v, oe_v, we_v, ack_v, busy_v, drv_v;
   logic [23:0] addr_c1;
   logic [31:0] wdata_c1;
   int          oe_cnt, ack_cnt, busy_cnt;

   initial begin
      n_sys_reset = 1'b0;
      req = 1'b1; req_we = 1'b0; req_addr = 24'h0; req_wdata = 32'h0;
      cfg_setup = 2'd0; cfg_strobe = 4'd0; cfg_hold = 2'd0; cfg_turn = 2'd0;
      mem_rdata = 32'h0;
      repeat (3) next_cycle();
      chk("reset busy", busy, 1'b0);
      chk("reset cs_n", mem_cs_n, 1'b1);
      chk("reset ack", ack, 1'b0);
      req = 1'b0;
      n_sys_reset = 1'b1;
      repeat (2) next_cycle();

      // Read: setup 1, strobe 2, hold 1, turn 2
      req = 1'b1; req_we = 1'b0; req_addr = 24'h0000AA;
      cfg_setup = 2'd1; cfg_strobe = 4'd2; cfg_hold = 2'd1; cfg_turn = 2'd2;
      next_cycle();
      req = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         mem_rdata = (i == 3) ? 32'hA5A50001 : 32'h5A5A0000 + i;
         @(negedge hclk);
         cs_v[i] = mem_cs_n; oe_v[i] = mem_oe_n; we_v[i] = mem_we_n;
         ack_v[i] = ack; busy_v[i] = busy;
         next_cycle();
      end
      chk("rd cs_n pattern", cs_v, 9'b111110000);
      chk("rd oe_n pattern", oe_v, 9'b111111001);
      chk("rd we_n pattern", we_v, 9'b111111111);
      chk("rd ack pattern", ack_v, 9'b000010000);
      chk("rd busy pattern", busy_v, 9'b001111111);
      chk("rd rdata", rdata, 32'hA5A50001);

      // Write with all cfg 0, req held so a second write follows
      req = 1'b1; req_we = 1'b1; req_addr = 24'h000123; req_wdata = 32'hDEADBEEF;
      cfg_setup = 2'd0; cfg_strobe = 4'd0; cfg_hold = 2'd0; cfg_turn = 2'd0;
      next_cycle();
      for (int i = 1; i <= 4; i++) begin
         @(negedge hclk);
         cs_v[i] = mem_cs_n; we_v[i] = mem_we_n; drv_v[i] = mem_drive;
         ack_v[i] = ack; busy_v[i] = busy;
         if (i == 1) begin
            addr_c1 = mem_addr;
            wdata_c1 = mem_wdata;
         end
         next_cycle();
      end
      req = 1'b0;
      chk("wr cs_n pattern", cs_v[4:1], 4'b0110);
      chk("wr we_n pattern", we_v[4:1], 4'b0110);
      chk("wr drive pattern", drv_v[4:1], 4'b1001);
      chk("wr ack pattern", ack_v[4:1], 4'b0010);
      chk("wr busy pattern", busy_v[4:1], 4'b1011);
      chk("wr addr", addr_c1, 24'h000123);
      chk("wr wdata", wdata_c1, 32'hDEADBEEF);
      chk("wr rdata kept", rdata, 32'hA5A50001);
      repeat (3) next_cycle();

      // Zero strobe read gives one strobe cycle
      req = 1'b1; req_we = 1'b0; req_addr = 24'h00BEEF; mem_rdata = 32'h0000CAFE;
      next_cycle();
      req = 1'b0;
      observe(5, oe_cnt, ack_cnt, busy_cnt);
      chk("strobe0 oe cycles", oe_cnt, 1);
      chk("strobe0 acks", ack_cnt, 1);
      chk("strobe0 rdata", rdata, 32'h0000CAFE);

      // cfg change after acceptance has no effect
      req = 1'b1; cfg_setup = 2'd1; cfg_strobe = 4'd3;
      next_cycle();
      req = 1'b0; cfg_strobe = 4'd15;
      observe(8, oe_cnt, ack_cnt, busy_cnt);
      chk("cfgchg oe cycles", oe_cnt, 3);
      chk("cfgchg busy cycles", busy_cnt, 5);

      // Reset in the middle of a write strobe
      req = 1'b1; req_we = 1'b1; req_addr = 24'h00F00D; req_wdata = 32'h13572468;
      cfg_setup = 2'd0; cfg_strobe = 4'd5; cfg_hold = 2'd0;
      next_cycle();
      req = 1'b0;
      repeat (2) next_cycle();
      chk("pre-reset we_n", mem_we_n, 1'b0);
      n_sys_reset = 1'b0;
      #1;
      chk("async we_n", mem_we_n, 1'b1);
      chk("async cs_n", mem_cs_n, 1'b1);
      chk("async drive", mem_drive, 1'b0);
      chk("async busy", busy, 1'b0);
      next_cycle();
      n_sys_reset = 1'b1;
      observe(6, oe_cnt, ack_cnt, busy_cnt);
      chk("post-reset acks", ack_cnt, 0);
      chk("post-reset busy", busy_cnt, 0);

      // Back-to-back reads, turn 3, req held through DONE
      req = 1'b1; req_we = 1'b0; req_addr = 24'h000777;
      cfg_setup = 2'd0; cfg_strobe = 4'd1; cfg_hold = 2'd0; cfg_turn = 2'd3;
      next_cycle();
      for (int i = 1; i <= 9; i++) begin
         mem_rdata = 32'h7000_0000 + i;
         @(negedge hclk);
         oe_v[i] = mem_oe_n; ack_v[i] = ack; busy_v[i] = busy;
         next_cycle();
      end
      req = 1'b0;
      chk("b2b oe_n pattern", oe_v, 9'b110111110);
      chk("b2b ack pattern", ack_v, 9'b010000010);
      chk("b2b busy pattern", busy_v, 9'b111011111);
      chk("b2b rdata", rdata, 32'h70000007);
      repeat (6) next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
